// File: rtl/mem_access_unit.sv
// Load/store front end for a single-cycle word memory: sub-word stores become
// read-modify-write, loads get lane extraction, and reads never overlap writes.
module mem_access_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter bit          RESP_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;

  logic              req_err;
  logic [31:0]       merged;
  logic [31:0]       load_data;
  logic [31:0]       rdata_raw;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  always_comb begin
    req_err = (req_size == 2'b11)
            | ((req_size == 2'b01) & req_addr[0])
            | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
  end

  // Store data merged into the word captured during READ (word stores bypass it).
  always_comb begin
    merged = word_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    sel_byte = word_q[{addr_q[1:0], 3'b000} +: 8];
    sel_half = word_q[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_data = {{24{signed_q & sel_byte[7]}}, sel_byte};
      2'b01:   load_data = {{16{signed_q & sel_half[15]}}, sel_half};
      default: load_data = word_q;
    endcase
    rdata_raw = (!err_q && !wr_q) ? load_data : 32'h0;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    size_d   = size_q;
    signed_d = signed_q;
    wr_d     = wr_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          size_d   = req_size;
          signed_d = req_signed;
          wr_d     = req_wr;
          err_d    = req_err;
          if (req_err) begin
            state_d = StResp;
          end else if (req_wr && (req_size == 2'b10)) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        word_d  = mem_data_out;
        state_d = wr_q ? StWrite : StResp;
      end
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == StIdle);
    resp_valid  = (state_q == StResp);
    resp_err    = resp_valid & err_q;
    mem_enable  = (state_q == StRead) || (state_q == StWrite);
    mem_wr      = (state_q == StWrite);
    mem_addr    = mem_enable ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_data_in = mem_wr ? merged : 32'h0;
    resp_rdata  = (resp_valid || !RESP_ZERO) ? rdata_raw : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
    end
  end

endmodule
